rx_frame_ctl: RTL and testbench
===============================

Name: rx_frame_ctl

Overview:
- Controller that sequences the V.4 bit-serial receiver core: arms/disarms its edge detectors, programs its frame length, and detects frame completion from the receiver's idle flag.
- On completion, it extracts data/parity/stop fields from the receiver shift register, checks them, and pushes data plus status into a receive FIFO read by the register interface.

Parameters:
- SHIFT_REG_WIDTH, 16, width of receiver shift register (must be >= 12)
- FIFO_DEPTH, 8, receive FIFO entries (power of two, >= 2)
- FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  receive enable
- data_bits_i  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits
- parity_i  in  2  0=none, 1=even, 2=odd, 3=none
- stop2_i  in  1  1=two stop bits
- clk_sel_i  in  2  {eedc, eedd} edge-source select passed to receiver when armed
- rx_bits_o  out  6  frame length to receiver bits_i
- rx_eedd_o  out  1  to receiver eedd_i
- rx_eedc_o  out  1  to receiver eedc_i
- rx_dat_i  in  SHIFT_REG_WIDTH  receiver dat_o
- rx_idle_i  in  1  receiver idle_o
- pop_i  in  1  read strobe, removes head entry
- rdata_o  out  8  head data, zero-extended (first-word fall-through)
- rstat_o  out  3  head status {break, framing_err, parity_err}
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- level_o  out  FIFO_AW+1  entry count
- overrun_o  out  1  sticky: frame dropped while FIFO full
- clr_ovr_i  in  1  clears overrun_o

Behaviour:
- Reset values: state DISABLED; rx_eedd_o=rx_eedc_o=0; rx_bits_o=0; FIFO empty (empty_o=1, full_o=0, level_o=0); rdata_o=0; rstat_o=0; overrun_o=0.
- Config (data_bits_i, parity_i, stop2_i, clk_sel_i) is latched only on the DISABLED->ARMED transition. Changes while enabled are ignored.
- rx_bits_o is registered: N = 1 + D + P + S, where D = 5..8, P = 1 if parity is even/odd, S = 1 or 2. Range 7..12.
- FSM:
  - DISABLED: edge enables 0. When enable_i=1: latch config, go ARMED.
  - ARMED: {rx_eedc_o, rx_eedd_o} = latched clk_sel. rx_idle_i=0 -> RECEIVING. enable_i=0 -> DISABLED.
  - RECEIVING: enables held. When rx_idle_i=1, capture rx_dat_i into the frame register, go CHECK, set discard = ~enable_i.
  - CHECK (one cycle): evaluate fields; push unless discard; next state ARMED if enable_i else DISABLED.
  - enable_i low during RECEIVING: enables drop to 0 next cycle, the receiver finishes the frame, and the frame is discarded (not pushed, no overrun).
- Field extraction, with W = SHIFT_REG_WIDTH and base B = W-N:
  - start bit = frame[B]
  - data bit k = frame[B+1+k] (LSB first)
  - parity = frame[B+1+D]
  - stop bits = frame[B+1+D+P], plus the next bit if S=2
- framing_err = start==1 or any stop==0.
- parity_err: even mode -> XOR(data, parity)==1; odd mode -> XOR(data, parity)==0; 0 when parity is none.
- break = all N frame bits 0; also forces framing_err=1.
- Latency: rx_idle_i rising is sampled at edge t; push occurs at edge t+1; empty_o falls after edge t+1.
- FIFO:
  - Push accepted if !full, or if full and pop_i in the same cycle (simultaneous push+pop keeps level).
  - pop_i when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push rejected when full -> overrun_o=1.
  - overrun_o set and clr_ovr_i in the same cycle: set wins.
- Asserting reset_i mid-frame returns to DISABLED immediately and empties the FIFO.

Decomposition:
- Package rx_frame_pkg: state encodings, parity mode constants (PAR_NONE/EVEN/ODD), status bit indices, entry width (11).
- Sub-module rx_fifo: synchronous FWFT FIFO with level, full/empty, and push-accept output used for overrun.

Test Plan:
- enable, 8N1, clk_sel=01: rx_bits_o=10. Receiver delivers 0x5A, start 0, stop 1 -> one entry: rdata_o=0x5A, rstat_o=000, level_o=1.
- 7E2, data 0x41 with wrong parity bit 1 -> rx_bits_o=11; entry rdata_o=0x41, rstat_o=001.
- 8N1 frame with stop bit 0 -> rstat_o=010; all-zero frame -> rstat_o=110, rdata_o=0x00.
- Push 9 frames, FIFO_DEPTH=8, no pops -> full_o=1, level_o=8, overrun_o=1, first 8 entries intact. clr_ovr_i -> overrun_o=0. Push coincident with pop when full -> accepted, level stays 8, no overrun.
- enable_i dropped mid-frame -> rx_eedd_o/rx_eedc_o go to 0 next cycle, frame not pushed, state DISABLED. Re-enable with new config -> new rx_bits_o value.
- reset_i asserted low during RECEIVING with 3 entries -> outputs at reset values on the same edge, empty_o=1.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive frame controller and its FIFO.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_ARMED     = 2'd1,
    ST_RECEIVING = 2'd2,
    ST_CHECK     = 2'd3
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned ST_PAR_BIT = 0;
  localparam int unsigned ST_FRM_BIT = 1;
  localparam int unsigned ST_BRK_BIT = 2;

  localparam int unsigned ENTRY_W = 11;

  function automatic logic has_parity(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  // N = start + (5 + dsel) data + parity + (1 + stop2) stop bits
  function automatic logic [5:0] frame_len(input logic [1:0] dsel, input logic [1:0] par,
                                           input logic stop2);
    return 6'd7 + {4'd0, dsel} + {5'd0, has_parity(par)} + {5'd0, stop2};
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word fall-through FIFO with level count; push_ok_o reports acceptance.
module rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 11
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o,
  output logic          push_ok_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          pop_ok;

  assign empty_o   = (level == '0);
  assign full_o    = (level == FULL_LVL);
  assign level_o   = level;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign push_ok_o = push_i & (~full_o | pop_i);
  assign pop_ok    = pop_i & ~empty_o;
  assign rdata_o   = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)    rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok_o, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/rx_frame_ctl.sv
// Sequences the bit-serial receiver, checks completed frames and queues
// data plus status for the register interface.
module rx_frame_ctl
  import rx_frame_pkg::*;
#(
  parameter int unsigned SHIFT_REG_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned FIFO_AW         = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic [1:0]                 data_bits_i,
  input  logic [1:0]                 parity_i,
  input  logic                       stop2_i,
  input  logic [1:0]                 clk_sel_i,
  output logic [5:0]                 rx_bits_o,
  output logic                       rx_eedd_o,
  output logic                       rx_eedc_o,
  input  logic [SHIFT_REG_WIDTH-1:0] rx_dat_i,
  input  logic                       rx_idle_i,
  input  logic                       pop_i,
  output logic [7:0]                 rdata_o,
  output logic [2:0]                 rstat_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [FIFO_AW:0]           level_o,
  output logic                       overrun_o,
  input  logic                       clr_ovr_i
);

  state_e                     state_q, state_d;
  logic [1:0]                 cfg_dsel_q, cfg_par_q, cfg_sel_q;
  logic                       cfg_stop2_q;
  logic [5:0]                 rx_bits_q;
  logic [1:0]                 eed_q;
  logic [SHIFT_REG_WIDTH-1:0] frame_q;
  logic                       discard_q;
  logic                       overrun_q;

  logic                       push, push_ok;
  logic [ENTRY_W-1:0]         entry, fifo_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED:  if (enable_i) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!enable_i)       state_d = ST_DISABLED;
        else if (!rx_idle_i) state_d = ST_RECEIVING;
      end
      ST_RECEIVING: if (rx_idle_i) state_d = ST_CHECK;
      ST_CHECK:     state_d = enable_i ? ST_ARMED : ST_DISABLED;
      default:      state_d = ST_DISABLED;
    endcase
  end

  // Once enable drops mid-frame the edge detectors stay off and the frame is
  // discarded, even if enable returns before the receiver goes idle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_DISABLED;
      cfg_dsel_q  <= '0;
      cfg_par_q   <= '0;
      cfg_sel_q   <= '0;
      cfg_stop2_q <= 1'b0;
      rx_bits_q   <= '0;
      eed_q       <= '0;
      frame_q     <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_DISABLED: begin
          if (enable_i) begin
            cfg_dsel_q  <= data_bits_i;
            cfg_par_q   <= parity_i;
            cfg_sel_q   <= clk_sel_i;
            cfg_stop2_q <= stop2_i;
            rx_bits_q   <= frame_len(data_bits_i, parity_i, stop2_i);
            eed_q       <= clk_sel_i;
            discard_q   <= 1'b0;
          end
        end
        ST_ARMED: if (!enable_i) eed_q <= '0;
        ST_RECEIVING: begin
          if (!enable_i) eed_q <= '0;
          discard_q <= discard_q | ~enable_i;
          if (rx_idle_i) frame_q <= rx_dat_i;
        end
        ST_CHECK: begin
          eed_q     <= enable_i ? cfg_sel_q : '0;
          discard_q <= 1'b0;
        end
        default: eed_q <= '0;
      endcase
    end
  end

  logic [SHIFT_REG_WIDTH-1:0] sh, ones, nmask;
  logic [5:0]                 base;
  logic [3:0]                 d_len;
  logic [4:0]                 sp;
  logic [1:0]                 stops;
  logic [7:0]                 data;
  logic                       par_b, brk, frm_err, par_err;
  logic [2:0]                 stat;

  // Frame occupies the top N bits of the shift register, start bit lowest
  always_comb begin
    base    = 6'(SHIFT_REG_WIDTH) - rx_bits_q;
    sh      = frame_q >> base;
    d_len   = 4'd5 + {2'b00, cfg_dsel_q};
    data    = 8'(sh >> 1) & (8'hFF >> (2'd3 - cfg_dsel_q));
    par_b   = 1'(sh >> (d_len + 4'd1));
    sp      = {1'b0, d_len} + 5'd1 + {4'd0, has_parity(cfg_par_q)};
    stops   = 2'(sh >> sp);
    ones    = '1;
    nmask   = ~(ones << rx_bits_q);
    brk     = ((sh & nmask) == '0);
    frm_err = sh[0] | ~stops[0] | (cfg_stop2_q & ~stops[1]) | brk;
    par_err = 1'b0;
    if (cfg_par_q == PAR_EVEN)     par_err = ^data ^ par_b;
    else if (cfg_par_q == PAR_ODD) par_err = ~(^data ^ par_b);
    stat             = '0;
    stat[ST_PAR_BIT] = par_err;
    stat[ST_FRM_BIT] = frm_err;
    stat[ST_BRK_BIT] = brk;
    entry            = {stat, data};
  end

  assign push = (state_q == ST_CHECK) && !discard_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)              overrun_q <= 1'b0;
    else if (push && !push_ok) overrun_q <= 1'b1;
    else if (clr_ovr_i)        overrun_q <= 1'b0;
  end

  rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .AW   (FIFO_AW),
    .DW   (ENTRY_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .push_i   (push),
    .pop_i    (pop_i),
    .wdata_i  (entry),
    .rdata_o  (fifo_rdata),
    .empty_o  (empty_o),
    .full_o   (full_o),
    .level_o  (level_o),
    .push_ok_o(push_ok)
  );

  assign rx_bits_o = rx_bits_q;
  assign rx_eedd_o = eed_q[0];
  assign rx_eedc_o = eed_q[1];
  assign rdata_o   = fifo_rdata[7:0];
  assign rstat_o   = fifo_rdata[10:8];
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_rx_frame_ctl.sv
// Scoreboard bench for rx_frame_ctl: frames built here, expected entries queued.
module tb_rx_frame_ctl;

  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         enable_i = 1'b0;
  logic [1:0]   data_bits_i = '0;
  logic [1:0]   parity_i = '0;
  logic         stop2_i = 1'b0;
  logic [1:0]   clk_sel_i = '0;
  logic [5:0]   rx_bits_o;
  logic         rx_eedd_o, rx_eedc_o;
  logic [W-1:0] rx_dat_i = '0;
  logic         rx_idle_i = 1'b1;
  logic         pop_i = 1'b0;
  logic [7:0]   rdata_o;
  logic [2:0]   rstat_o;
  logic         empty_o, full_o;
  logic [3:0]   level_o;
  logic         overrun_o;
  logic         clr_ovr_i = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  logic [10:0] sb_q[$];

  rx_frame_ctl #(.SHIFT_REG_WIDTH(W), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .data_bits_i(data_bits_i),
    .parity_i(parity_i), .stop2_i(stop2_i), .clk_sel_i(clk_sel_i), .rx_bits_o(rx_bits_o),
    .rx_eedd_o(rx_eedd_o), .rx_eedc_o(rx_eedc_o), .rx_dat_i(rx_dat_i), .rx_idle_i(rx_idle_i),
    .pop_i(pop_i), .rdata_o(rdata_o), .rstat_o(rstat_o), .empty_o(empty_o), .full_o(full_o),
    .level_o(level_o), .overrun_o(overrun_o), .clr_ovr_i(clr_ovr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [W-1:0] mk_frame(input logic [7:0] data, input int dbits,
      input logic [1:0] par, input logic stop2, input logic flip_par,
      input logic start_b, input logic stop_b, input logic [W-1:0] junk);
    logic [11:0]  f;
    logic [W-1:0] low_mask;
    logic         p;
    int           n;
    f = '0;
    n = 0;
    f = f | (12'(start_b) << n); n++;
    for (int k = 0; k < dbits; k++) begin
      f = f | (12'(data[k]) << n); n++;
    end
    if (par == 2'd1 || par == 2'd2) begin
      p = 1'b0;
      for (int k = 0; k < dbits; k++) p = p ^ data[k];
      if (par == 2'd2) p = ~p;
      f = f | (12'(p ^ flip_par) << n); n++;
    end
    f = f | (12'(stop_b) << n); n++;
    if (stop2) begin
      f = f | (12'(1) << n); n++;
    end
    low_mask = (16'h1 << (W - n)) - 16'h1;
    return ({4'b0, f} << (W - n)) | (junk & low_mask);
  endfunction

  task automatic configure(input logic [1:0] dsel, input logic [1:0] par, input logic s2,
                           input logic [1:0] sel);
    enable_i = 1'b0;
    tick;
    tick;
    data_bits_i = dsel;
    parity_i    = par;
    stop2_i     = s2;
    clk_sel_i   = sel;
    enable_i    = 1'b1;
    tick;
  endtask

  task automatic send(input logic [W-1:0] frame, input logic exp_push,
                      input logic [10:0] exp_entry, input logic do_pop);
    logic [10:0] e;
    rx_idle_i = 1'b0;
    tick;
    tick;
    rx_dat_i  = frame;
    rx_idle_i = 1'b1;
    tick;
    if (do_pop) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 11'h7FF;
      check_val("head_before_pop", {21'd0, rstat_o, rdata_o}, {21'd0, e});
      pop_i = 1'b1;
    end
    if (exp_push) sb_q.push_back(exp_entry);
    tick;
    pop_i = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    logic [10:0] e;
    int guard;
    guard = 0;
    while (!empty_o && guard < 16) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 11'h7FF;
      check_val(tag, {21'd0, rstat_o, rdata_o}, {21'd0, e});
      pop_i = 1'b1;
      tick;
      pop_i = 1'b0;
      guard++;
    end
    check_val({tag, "_left"}, sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_bits"},  rx_bits_o, 0);
    check_val({tag, "_eedd"},  rx_eedd_o, 0);
    check_val({tag, "_eedc"},  rx_eedc_o, 0);
    check_val({tag, "_empty"}, empty_o, 1);
    check_val({tag, "_full"},  full_o, 0);
    check_val({tag, "_level"}, level_o, 0);
    check_val({tag, "_rdata"}, rdata_o, 0);
    check_val({tag, "_rstat"}, rstat_o, 0);
    check_val({tag, "_ovr"},   overrun_o, 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    #20;
    reset_i = 1'b1;
    tick;

    // 8N1, clk_sel 01
    configure(2'd3, 2'd0, 1'b0, 2'b01);
    check_val("8n1_bits", rx_bits_o, 10);
    check_val("8n1_eedd", rx_eedd_o, 1);
    check_val("8n1_eedc", rx_eedc_o, 0);
    send(mk_frame(8'h5A, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015), 1'b1, {3'b000, 8'h5A}, 1'b0);
    check_val("8n1_level", level_o, 1);
    check_val("8n1_empty", empty_o, 0);
    drain_all("8n1_entry");

    // 7E2 with bad and good parity
    configure(2'd2, 2'd1, 1'b1, 2'b10);
    check_val("7e2_bits", rx_bits_o, 11);
    check_val("7e2_eedc", rx_eedc_o, 1);
    check_val("7e2_eedd", rx_eedd_o, 0);
    send(mk_frame(8'h41, 7, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h001F), 1'b1, {3'b001, 8'h41}, 1'b0);
    send(mk_frame(8'h33, 7, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000A), 1'b1, {3'b000, 8'h33}, 1'b0);
    drain_all("7e2_entry");

    // Framing error and break on 8N1, then 5O1
    configure(2'd3, 2'd0, 1'b0, 2'b01);
    send(mk_frame(8'hC3, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h003F), 1'b1, {3'b010, 8'hC3}, 1'b0);
    send(mk_frame(8'h00, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h002B), 1'b1, {3'b110, 8'h00}, 1'b0);
    configure(2'd0, 2'd2, 1'b0, 2'b11);
    check_val("5o1_bits", rx_bits_o, 8);
    send(mk_frame(8'h15, 5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF), 1'b1, {3'b000, 8'h15}, 1'b0);
    send(mk_frame(8'h0A, 5, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000), 1'b1, {3'b001, 8'h0A}, 1'b0);
    drain_all("err_entry");

    // Fill past capacity, clear overrun, then push while popping at full
    configure(2'd3, 2'd0, 1'b0, 2'b01);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] d;
      d = 8'(i * 17 + 3);
      send(mk_frame(d, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(i)), i < 8, {3'b000, d}, 1'b0);
    end
    check_val("ovf_full", full_o, 1);
    check_val("ovf_level", level_o, 8);
    check_val("ovf_overrun", overrun_o, 1);
    clr_ovr_i = 1'b1;
    tick;
    clr_ovr_i = 1'b0;
    check_val("ovf_clr", overrun_o, 0);
    send(mk_frame(8'hEE, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001), 1'b1, {3'b000, 8'hEE}, 1'b1);
    check_val("pp_level", level_o, 8);
    check_val("pp_full", full_o, 1);
    check_val("pp_overrun", overrun_o, 0);
    drain_all("ovf_entry");

    // Enable dropped mid-frame
    configure(2'd3, 2'd0, 1'b0, 2'b11);
    check_val("abort_eedd_on", rx_eedd_o, 1);
    check_val("abort_eedc_on", rx_eedc_o, 1);
    rx_idle_i = 1'b0;
    tick;
    enable_i = 1'b0;
    tick;
    check_val("abort_eedd_off", rx_eedd_o, 0);
    check_val("abort_eedc_off", rx_eedc_o, 0);
    rx_dat_i  = mk_frame(8'h77, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    rx_idle_i = 1'b1;
    tick;
    tick;
    check_val("abort_empty", empty_o, 1);
    check_val("abort_level", level_o, 0);
    check_val("abort_ovr", overrun_o, 0);
    data_bits_i = 2'd0;
    parity_i    = 2'd0;
    stop2_i     = 1'b0;
    clk_sel_i   = 2'b01;
    enable_i    = 1'b1;
    tick;
    check_val("reen_bits", rx_bits_o, 7);
    check_val("reen_eedd", rx_eedd_o, 1);
    check_val("reen_eedc", rx_eedc_o, 0);

    // Reset asserted during reception with three queued entries
    configure(2'd3, 2'd0, 1'b0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = 8'(8'h90 + i);
      send(mk_frame(d, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000), 1'b1, {3'b000, d}, 1'b0);
    end
    check_val("pre_rst_level", level_o, 3);
    rx_idle_i = 1'b0;
    tick;
    #2;
    reset_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb_q.delete();
    rx_idle_i = 1'b1;
    enable_i  = 1'b0;
    tick;
    reset_i = 1'b1;
    tick;
    check_val("post_rst_eedd", rx_eedd_o, 0);
    check_val("post_rst_empty", empty_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
